// File: rtl/sync_fifo_wm.sv
// Single-clock FIFO with watermarks, occupancy count, sticky error flags
// and a build-time choice of registered or fall-through read port.
module sync_fifo_wm #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int ADDRESS_BITS    = 4,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter bit FWFT            = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WINC,
    input  logic [DATA_WIDTH-1:0]   W_DATA,
    input  logic                    RINC,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   R_DATA,
    output logic                    R_VALID,
    output logic                    W_FULL,
    output logic                    R_EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [ADDRESS_BITS:0]   COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int PW = ADDRESS_BITS + 1;
    localparam logic [PW-1:0] AF_C = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_C = PW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           wptr;
    logic [PW-1:0]           rptr;
    logic [ADDRESS_BITS-1:0] waddr;
    logic [ADDRESS_BITS-1:0] raddr;
    logic                    wr_acc;
    logic                    rd_acc;

    // Status comes only from registered pointers, never from WINC/RINC.
    always_comb begin
        waddr        = wptr[ADDRESS_BITS-1:0];
        raddr        = rptr[ADDRESS_BITS-1:0];
        COUNT        = wptr - rptr;
        R_EMPTY      = (wptr == rptr);
        W_FULL       = (wptr[ADDRESS_BITS] != rptr[ADDRESS_BITS])
                       && (waddr == raddr);
        ALMOST_FULL  = (COUNT >= AF_C);
        ALMOST_EMPTY = (COUNT <= AE_C);
        wr_acc       = WINC && !W_FULL;
        rd_acc       = RINC && !R_EMPTY;
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[waddr] <= W_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + ONE;
            end
        end
    end

    // A new error event in the same cycle as CLR_ERR keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WINC && W_FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end
            if (RINC && R_EMPTY) begin
                UNDERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                UNDERFLOW <= 1'b0;
            end
        end
    end

    if (FWFT) begin : g_fwft
        // Empty forces zero so stale memory never leaks onto R_DATA.
        always_comb begin
            R_VALID = !R_EMPTY;
            R_DATA  = R_EMPTY ? '0 : mem[raddr];
        end
    end else begin : g_reg
        always_ff @(posedge CLK) begin
            if (RST) begin
                R_DATA  <= '0;
                R_VALID <= 1'b0;
            end else begin
                R_VALID <= rd_acc;
                if (rd_acc) begin
                    R_DATA <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Randomised scoreboard bench: one registered-read and one fall-through
// instance share stimulus and are checked against a queue-based model.
module tb_sync_fifo_wm;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AB    = 4;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] w_data = '0;

    logic [DW-1:0] r_data0, r_data1;
    logic          r_valid0, r_valid1;
    logic          w_full0, w_full1;
    logic          r_empty0, r_empty1;
    logic          af0, af1, ae0, ae1;
    logic [AB:0]   count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    sync_fifo_wm #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDRESS_BITS(AB),
        .ALMOST_FULL_TH(AFT), .ALMOST_EMPTY_TH(AET), .FWFT(1'b0)
    ) u_reg (
        .CLK(clk), .RST(rst), .WINC(winc), .W_DATA(w_data),
        .RINC(rinc), .CLR_ERR(clr_err),
        .R_DATA(r_data0), .R_VALID(r_valid0), .W_FULL(w_full0),
        .R_EMPTY(r_empty0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
        .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    sync_fifo_wm #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDRESS_BITS(AB),
        .ALMOST_FULL_TH(AFT), .ALMOST_EMPTY_TH(AET), .FWFT(1'b1)
    ) u_fwft (
        .CLK(clk), .RST(rst), .WINC(winc), .W_DATA(w_data),
        .RINC(rinc), .CLR_ERR(clr_err),
        .R_DATA(r_data1), .R_VALID(r_valid1), .W_FULL(w_full1),
        .R_EMPTY(r_empty1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
        .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_reg_q[$];
    logic [DW-1:0] exp_fwft_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        logic [31:0] fdat;
        sz   = mq.size();
        fdat = (sz != 0) ? 32'(mq[0]) : 32'h0;
        chk("count_reg", 32'(count0), sz);
        chk("count_fwft", 32'(count1), sz);
        chk("full_reg", 32'(w_full0), 32'(sz == DEPTH));
        chk("full_fwft", 32'(w_full1), 32'(sz == DEPTH));
        chk("empty_reg", 32'(r_empty0), 32'(sz == 0));
        chk("empty_fwft", 32'(r_empty1), 32'(sz == 0));
        chk("afull_reg", 32'(af0), 32'(sz >= AFT));
        chk("afull_fwft", 32'(af1), 32'(sz >= AFT));
        chk("aempty_reg", 32'(ae0), 32'(sz <= AET));
        chk("aempty_fwft", 32'(ae1), 32'(sz <= AET));
        chk("ovf_reg", 32'(ovf0), 32'(m_ovf));
        chk("ovf_fwft", 32'(ovf1), 32'(m_ovf));
        chk("unf_reg", 32'(unf0), 32'(m_unf));
        chk("unf_fwft", 32'(unf1), 32'(m_unf));
        chk("rvalid_reg", 32'(r_valid0), 32'(m_rvalid));
        chk("rdata_reg", 32'(r_data0), 32'(m_rdata));
        chk("rvalid_fwft", 32'(r_valid1), 32'(sz != 0));
        chk("rdata_fwft", 32'(r_data1), fdat);
    endtask

    // Drive one cycle, advance the model on the edge, then check status.
    task automatic step(input bit r, input bit w, input logic [DW-1:0] d,
                        input bit rd, input bit c);
        bit full, empty;
        rst = r; winc = w; w_data = d; rinc = rd; clr_err = c;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_reg_q.delete();
            exp_fwft_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
            m_rvalid = 1'b0; m_rdata = '0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            m_rvalid = rd && !empty;
            if (m_rvalid) begin
                m_rdata = mq.pop_front();
                exp_reg_q.push_back(m_rdata);
            end
            if (w && !full) begin
                mq.push_back(d);
                exp_fwft_q.push_back(d);
            end
            if (w && full) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (rd && empty) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
        end
        #1;
        check_status();
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++)
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("drained", mq.size(), 0);
    endtask

    // Output monitors: pop the scoreboard whenever a word is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if (r_valid0) begin
                chk("reg_word_pending", 32'(exp_reg_q.size() != 0), 1);
                if (exp_reg_q.size() != 0)
                    chk("reg_word", 32'(r_data0), 32'(exp_reg_q.pop_front()));
            end
            chk("fwft_valid_eq_not_empty", 32'(r_valid1), 32'(!r_empty1));
            if (r_valid1 && rinc) begin
                chk("fwft_word_pending", 32'(exp_fwft_q.size() != 0), 1);
                if (exp_fwft_q.size() != 0)
                    chk("fwft_word", 32'(r_data1), 32'(exp_fwft_q.pop_front()));
            end
        end
    end

    initial begin
        int nxt;
        bit w, rd;

        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        chk("reset_count", 32'(count0), 0);
        chk("reset_rvalid_fwft", 32'(r_valid1), 0);

        for (int i = 1; i <= 17; i++)
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(w_full0), 1);
        chk("fill_ovf", 32'(ovf0), 1);

        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("drain_unf", 32'(unf0), 1);
        chk("drain_last", 32'(r_data0), 16);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf1), 0);
        chk("clr_unf", 32'(unf1), 0);

        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 8'(110 + i), 1'b1, 1'b0);
        chk("simul_count5", 32'(count0), 5);
        for (int i = 0; i < DEPTH && mq.size() < DEPTH; i++)
            step(1'b0, 1'b1, 8'(130 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_both_count", 32'(count1), 15);
        chk("full_both_ovf", 32'(ovf1), 1);
        step(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hE2, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(ovf0), 1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_after", 32'(ovf0), 0);
        drain();

        nxt = 0;
        for (int c = 0; c < 2000 && !(nxt == 40 && mq.size() == 0); c++) begin
            w  = (nxt < 40) && (mq.size() < DEPTH);
            rd = 1'($urandom_range(0, 1));
            step(1'b0, w, 8'(nxt), rd, 1'b0);
            if (w) nxt++;
        end
        chk("wrap_done", 32'(nxt == 40 && mq.size() == 0), 1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        drain();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count0), 9);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("mid_rst_empty", 32'(r_empty1), 1);
        chk("mid_rst_rvalid", 32'(r_valid1), 0);
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_fwft", 32'(r_data1), 32'hA5);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("a5_reg", 32'(r_data0), 32'hA5);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        chk("reg_sb_empty", exp_reg_q.size(), 0);
        chk("fwft_sb_empty", exp_fwft_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
